// File: rtl/flappy_pkg.sv
// Shared definitions for the score/display path: game state encoding,
// seven-segment codes (abcdefg, active-low) and a saturating BCD increment.
package flappy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } game_state_t;

    localparam logic [6:0] SSD_0     = 7'b0000001;
    localparam logic [6:0] SSD_1     = 7'b1001111;
    localparam logic [6:0] SSD_2     = 7'b0010010;
    localparam logic [6:0] SSD_3     = 7'b0000110;
    localparam logic [6:0] SSD_4     = 7'b1001100;
    localparam logic [6:0] SSD_5     = 7'b0100100;
    localparam logic [6:0] SSD_6     = 7'b0100000;
    localparam logic [6:0] SSD_7     = 7'b0001111;
    localparam logic [6:0] SSD_8     = 7'b0000000;
    localparam logic [6:0] SSD_9     = 7'b0000100;
    localparam logic [6:0] SSD_BLANK = 7'b1111111;

    // Two-digit BCD increment that sticks at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/ssd_digit_decoder.sv
// Combinational BCD digit to seven-segment cathode decoder with blank and
// decimal-point control; outputs {Ca..Cg, Dp}, all active-low.
module ssd_digit_decoder
    import flappy_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dp_on,
    output logic [7:0] cathodes
);

    logic [6:0] seg;
    logic       valid;

    always_comb begin
        // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latch).
        seg   = SSD_BLANK;
        valid = 1'b1;
        case (digit)
            4'd0: seg = SSD_0;
            4'd1: seg = SSD_1;
            4'd2: seg = SSD_2;
            4'd3: seg = SSD_3;
            4'd4: seg = SSD_4;
            4'd5: seg = SSD_5;
            4'd6: seg = SSD_6;
            4'd7: seg = SSD_7;
            4'd8: seg = SSD_8;
            4'd9: seg = SSD_9;
            default: valid = 1'b0;
        endcase
        cathodes = (blank || !valid) ? 8'hFF : {seg, ~dp_on};
    end

endmodule

// File: rtl/score_display.sv
// Score keeper for the game core: synchronizes game events, tracks current and
// high score in BCD, and time-multiplexes both onto the 4-digit display.
module score_display
    import flappy_pkg::*;
#(
    parameter int SCAN_BITS = 18,
    parameter bit BLANK_LZ  = 1'b1
) (
    input  logic       board_clk,
    input  logic       Reset,
    input  logic       score_evt,
    input  logic       game_clr,
    input  logic       lose,
    output logic [7:0] score_bcd,
    output logic [7:0] hiscore_bcd,
    output logic       game_over,
    output logic [3:0] an,
    output logic [7:0] cathodes
);

    localparam int CNT_W = SCAN_BITS + 2;

    // [0],[1] synchronize, [2] holds the previous synchronized value.
    logic [2:0] score_sync, clr_sync, lose_sync;
    logic       rise_score, rise_clr, rise_lose;

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            score_sync <= '0;
            clr_sync   <= '0;
            lose_sync  <= '0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value, which is what makes this a shift chain.
            score_sync <= {score_sync[1:0], score_evt};
            clr_sync   <= {clr_sync[1:0], game_clr};
            lose_sync  <= {lose_sync[1:0], lose};
        end
    end

    assign rise_score = score_sync[1] & ~score_sync[2];
    assign rise_clr   = clr_sync[1] & ~clr_sync[2];
    assign rise_lose  = lose_sync[1] & ~lose_sync[2];

    game_state_t state, state_nxt;

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_OVER: if (rise_clr)  state_nxt = ST_PLAY;
            ST_PLAY:          if (rise_lose) state_nxt = ST_OVER;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    logic [7:0] score_q, hiscore_q, score_eff;

    // A point landing on the losing cycle still counts toward the high score.
    assign score_eff = rise_score ? bcd_inc(score_q) : score_q;

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            score_q   <= '0;
            hiscore_q <= '0;
        end else if (state == ST_PLAY) begin
            score_q <= score_eff;
            if (rise_lose && (score_eff > hiscore_q))
                hiscore_q <= score_eff;
        end else if (rise_clr) begin
            score_q <= '0;
        end
    end

    assign score_bcd   = score_q;
    assign hiscore_bcd = hiscore_q;
    assign game_over   = (state == ST_OVER);

    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [1:0]       sel_nxt;
    logic [3:0]       digit, an_nxt;
    logic             blank, dp_on;
    logic [7:0]       cath_nxt;

    // Decode for the slot the counter is entering so an/cathodes track the counter exactly.
    assign cnt_nxt = cnt_q + CNT_W'(1);
    assign sel_nxt = cnt_nxt[CNT_W-1 -: 2];

    always_comb begin
        digit  = score_q[3:0];
        blank  = 1'b0;
        dp_on  = 1'b0;
        an_nxt = 4'b1110;
        case (sel_nxt)
            2'd0: ;
            2'd1: begin
                digit  = score_q[7:4];
                blank  = BLANK_LZ && (score_q[7:4] == 4'd0);
                an_nxt = 4'b1101;
            end
            2'd2: begin
                digit  = hiscore_q[3:0];
                dp_on  = (state == ST_OVER);
                an_nxt = 4'b1011;
            end
            default: begin
                digit  = hiscore_q[7:4];
                blank  = BLANK_LZ && (hiscore_q[7:4] == 4'd0);
                an_nxt = 4'b0111;
            end
        endcase
    end

    ssd_digit_decoder u_decoder (
        .digit    (digit),
        .blank    (blank),
        .dp_on    (dp_on),
        .cathodes (cath_nxt)
    );

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            cnt_q    <= '0;
            an       <= 4'b1110;
            cathodes <= 8'b0000_0011;
        end else begin
            cnt_q    <= cnt_nxt;
            an       <= an_nxt;
            cathodes <= cath_nxt;
        end
    end

endmodule
